// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - shared widths, defaults and fetch entry layout
// Purpose: constants and types shared by the fetch queue, its FIFO and the decode stage.
// Ports: none (package).
package instr_fetch_queue_pkg;

  localparam int IW            = 16;  // instruction width
  localparam int AW            = 16;  // byte address width
  localparam int DEPTH_DEFAULT = 4;   // default FIFO entries

  localparam logic [AW-1:0] PC_INC = AW'(2);

  // Fetch entry as seen by decode: PC in the upper half, instruction below.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - memory and decode handshake bundle for the fetch queue
// Purpose: groups the instruction-memory req/ack bus, the decode valid/ready bus and redirect.
// Ports (master = fetch queue side):
//   imem_req/imem_addr out, imem_ack/imem_rdata in   - instruction memory
//   ir/ir_pc/ir_valid out, ir_ready in               - decode/execute
//   redirect/redirect_pc in                          - branch resolution
interface instr_fetch_queue_if;
  import instr_fetch_queue_pkg::*;

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, ir, ir_pc, ir_valid,
    input  imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, ir, ir_pc, ir_valid,
    output imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// rtl/instr_fetch_queue_fetch_fifo.sv - synchronous FIFO of fetch entries with flush
// Purpose: buffers {pc, instr} entries between instruction memory and decode.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   push, push_data   - write one entry (ignored when full or flushing)
//   pop               - drop the head entry (ignored when empty or flushing)
//   flush             - empty the FIFO and reset the pointers
//   count             - number of stored entries
//   head              - head entry; holds the last shown head while empty
module fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  last_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & (count != (PW+1)'(DEPTH));
  assign do_pop  = pop & (count != '0);

  // Once empty, decode keeps seeing the last entry it was shown.
  assign head = (count != '0) ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (count != '0) last_q <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + (PW+1)'(1);
          2'b01:   count <= count - (PW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch with req/ack memory bus and decode queue
// Purpose: issues sequential fetches, buffers returned words with their PCs, and
//          flushes/refetches on a branch redirect.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - instr_fetch_queue_if.master (memory bus, decode bus, redirect)
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int            DEPTH    = DEPTH_DEFAULT,
  parameter logic [AW-1:0] PC_RESET = 16'h0000
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] addr_q;       // address of the request in flight
  logic          outstanding;
  logic          discard;      // in-flight completion belongs to a flushed stream
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          req;
  logic          accept;
  logic          push;
  logic          pop;
  logic          space;

  // Only issue when the word is guaranteed a slot; an in-flight request is
  // always held until acked, even across a redirect. Reset forces req low.
  assign space  = count < CW'(DEPTH);
  assign req    = rst_n & (outstanding | (space & ~bus.redirect));
  assign accept = req & bus.imem_ack;
  assign push   = accept & ~discard & ~bus.redirect;
  assign pop    = bus.ir_valid & bus.ir_ready;

  assign push_data = '{pc: fetch_pc, instr: bus.imem_rdata};

  assign bus.imem_req  = req;
  assign bus.imem_addr = outstanding ? addr_q : fetch_pc;
  assign bus.ir_valid  = (count != '0);
  assign bus.ir        = head.instr;
  assign bus.ir_pc     = head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= PC_RESET;
      addr_q      <= PC_RESET;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      outstanding <= req & ~bus.imem_ack;
      addr_q      <= bus.imem_addr;

      if (bus.redirect)
        fetch_pc <= bus.redirect_pc & ~AW'(1);
      else if (push)
        fetch_pc <= fetch_pc + PC_INC;

      // A redirect can only see req high here because of an in-flight
      // request; its eventual data must be thrown away.
      if (bus.redirect && req && !bus.imem_ack)
        discard <= 1'b1;
      else if (accept)
        discard <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_queue_if bus();

  instr_fetch_queue #(.DEPTH(4), .PC_RESET(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int wait_cnt = 0;

  typedef struct {
    bit          restart;
    int          lat;
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_ir;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  function automatic void add(input bit rs, input int l, input logic rdy, input logic redir,
                              input logic [15:0] rpc, input logic ereq, input logic [15:0] eaddr,
                              input logic evalid, input logic [15:0] epc, input logic [15:0] eir);
    vec_t v;
    v.restart = rs; v.lat = l; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evalid; v.exp_pc = epc; v.exp_ir = eir;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive decode/redirect inputs at the falling edge, then let the
  // memory model answer the (combinational) request with its latency.
  task automatic tick(input logic rdy, input logic redir, input logic [15:0] rpc);
    @(negedge clk);
    bus.ir_ready    = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    #1;
    bus.imem_rdata = pat(bus.imem_addr);
    bus.imem_ack   = bus.imem_req && (wait_cnt >= lat - 1);
    if (bus.imem_req && !bus.imem_ack) wait_cnt++;
    else wait_cnt = 0;
    #1;
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    bus.ir_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    lat = l; wait_cnt = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit saw6;
    logic [15:0] next_addr;

    // Streaming, immediate ack, decode always ready
    for (int k = 0; k < 6; k++)
      add(k == 0, 1, 1'b1, 1'b0, 16'h0, 1'b1, 16'(2*k), k > 0,
          k > 0 ? 16'(2*(k-1)) : 16'h0, k > 0 ? pat(16'(2*(k-1))) : 16'h0);
    // Fill with decode stalled, then a single pop
    add(1, 1, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    add(0, 1, 0, 0, 0, 1, 16'h0002, 1, 16'h0000, pat(16'h0000));
    add(0, 1, 0, 0, 0, 1, 16'h0004, 1, 16'h0000, pat(16'h0000));
    add(0, 1, 0, 0, 0, 1, 16'h0006, 1, 16'h0000, pat(16'h0000));
    add(0, 1, 0, 0, 0, 0, 16'h0008, 1, 16'h0000, pat(16'h0000));
    add(0, 1, 1, 0, 0, 0, 16'h0008, 1, 16'h0000, pat(16'h0000));
    add(0, 1, 0, 0, 0, 1, 16'h0008, 1, 16'h0002, pat(16'h0002));
    add(0, 1, 0, 0, 0, 0, 16'h000A, 1, 16'h0002, pat(16'h0002));
    // Redirect in the same cycle as an ack and a pop, odd target
    add(1, 2, 0, 0, 0,        1, 16'h0000, 0, 16'h0000, 16'h0000);
    add(0, 2, 0, 0, 0,        1, 16'h0000, 0, 16'h0000, 16'h0000);
    add(0, 2, 0, 0, 0,        1, 16'h0002, 1, 16'h0000, pat(16'h0000));
    add(0, 2, 1, 1, 16'h0013, 1, 16'h0002, 1, 16'h0000, pat(16'h0000));
    add(0, 2, 1, 0, 0,        1, 16'h0012, 0, 16'h0000, pat(16'h0000));
    add(0, 2, 1, 0, 0,        1, 16'h0012, 0, 16'h0000, pat(16'h0000));
    add(0, 2, 1, 0, 0,        1, 16'h0014, 1, 16'h0012, pat(16'h0012));
    // Address wrap at the top of memory
    add(1, 1, 1, 1, 16'hFFFC, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    add(0, 1, 1, 0, 0,        1, 16'hFFFC, 0, 16'h0000, 16'h0000);
    add(0, 1, 1, 0, 0,        1, 16'hFFFE, 1, 16'hFFFC, pat(16'hFFFC));
    add(0, 1, 1, 0, 0,        1, 16'h0000, 1, 16'hFFFE, pat(16'hFFFE));
    add(0, 1, 1, 0, 0,        1, 16'h0002, 1, 16'h0000, pat(16'h0000));

    // Reset state
    bus.ir_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.imem_ack = 1'b1; bus.imem_rdata = '0;
    #3;
    check("reset req",   16'(bus.imem_req), 16'h0);
    check("reset addr",  bus.imem_addr, 16'h0000);
    check("reset valid", 16'(bus.ir_valid), 16'h0);
    check("reset ir",    bus.ir, 16'h0000);
    check("reset ir_pc", bus.ir_pc, 16'h0000);

    foreach (vecs[i]) begin
      if (vecs[i].restart) do_reset(vecs[i].lat);
      tick(vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
      check($sformatf("v%0d req", i),   16'(bus.imem_req), 16'(vecs[i].exp_req));
      check($sformatf("v%0d addr", i),  bus.imem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d valid", i), 16'(bus.ir_valid), 16'(vecs[i].exp_valid));
      check($sformatf("v%0d ir_pc", i), bus.ir_pc, vecs[i].exp_pc);
      check($sformatf("v%0d ir", i),    bus.ir, vecs[i].exp_ir);
    end

    // Latency 3: redirect one cycle after the request to 0006 is issued
    do_reset(3);
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      tick(1'b1, 1'b0, 16'h0);
      if (bus.imem_req && bus.imem_addr == 16'h0006) found = 1;
    end
    check("lat req 0006 seen", 16'(found), 16'h1);
    tick(1'b1, 1'b1, 16'h0040);
    check("lat redirect req held", 16'(bus.imem_req), 16'h1);
    check("lat redirect addr held", bus.imem_addr, 16'h0006);
    tick(1'b1, 1'b0, 16'h0);
    check("lat discard valid", 16'(bus.ir_valid), 16'h0);
    check("lat discard addr", bus.imem_addr, 16'h0006);
    found = 0; saw6 = 0; next_addr = 16'h0006;
    for (int n = 0; n < 20 && !found; n++) begin
      tick(1'b1, 1'b0, 16'h0);
      if (bus.ir_valid && bus.ir_pc == 16'h0006) saw6 = 1;
      if (bus.imem_req && bus.imem_addr != 16'h0006) begin
        found = 1; next_addr = bus.imem_addr;
      end
    end
    check("lat next req addr", next_addr, 16'h0040);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick(1'b1, 1'b0, 16'h0);
      if (bus.ir_valid) found = 1;
      if (bus.ir_valid && bus.ir_pc == 16'h0006) saw6 = 1;
    end
    check("lat valid after flush", 16'(found), 16'h1);
    check("lat first ir_pc", bus.ir_pc, 16'h0040);
    check("lat first ir", bus.ir, pat(16'h0040));
    check("lat dropped word absent", 16'(saw6), 16'h0);

    // Asynchronous reset mid-request with two queued entries
    do_reset(1);
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0);
    lat = 3;
    tick(1'b0, 1'b0, 16'h0);
    check("ar pre valid", 16'(bus.ir_valid), 16'h1);
    check("ar pre ir", bus.ir, pat(16'h0000));
    @(posedge clk);
    #2;
    check("ar pre req", 16'(bus.imem_req), 16'h1);
    check("ar pre addr", bus.imem_addr, 16'h0004);
    rst_n = 1'b0;
    #1;
    check("ar req", 16'(bus.imem_req), 16'h0);
    check("ar addr", bus.imem_addr, 16'h0000);
    check("ar valid", 16'(bus.ir_valid), 16'h0);
    check("ar ir", bus.ir, 16'h0000);
    check("ar ir_pc", bus.ir_pc, 16'h0000);
    lat = 1; wait_cnt = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(1'b1, 1'b0, 16'h0);
    check("ar restart req", 16'(bus.imem_req), 16'h1);
    check("ar restart addr", bus.imem_addr, 16'h0000);
    tick(1'b1, 1'b0, 16'h0);
    check("ar restart ir_pc", bus.ir_pc, 16'h0000);
    check("ar restart valid", 16'(bus.ir_valid), 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Upstream fetch stage for the 16-bit single-cycle CPU datapath. It issues requests to instruction memory over a req/ack handshake that tolerates variable latency, buffers returned instruction words with their PCs in a small FIFO, and presents them to decode/execute with a valid/ready handshake. A redirect input from branch resolution flushes the buffer and restarts fetch at the branch target.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- PC_RESET, 16'h0000: first fetch address after reset; byte address.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- imem_req, output, 1: fetch request, held until acknowledged.
- imem_addr, output, 16: byte address of the request; bit 0 always 0.
- imem_ack, input, 1: memory accepts and returns data, sampled when imem_req=1.
- imem_rdata, input, 16: instruction word, valid in the imem_ack cycle.
- ir, output, 16: head-of-queue instruction.
- ir_pc, output, 16: byte address of ir.
- ir_valid, output, 1: queue non-empty.
- ir_ready, input, 1: consumer takes the head this cycle.
- redirect, input, 1: branch taken; flush and refetch.
- redirect_pc, input, 16: new fetch address; bit 0 is ignored and forced to 0.

## Operation
- Registers:
  - fetch_pc (16 bits)
  - outstanding (1 bit)
  - discard (1 bit)
  - FIFO of DEPTH entries of {pc[15:0], instr[15:0]}, with read/write pointers and a count.
- Issue rule:
  - imem_req=1 whenever a request is outstanding.
  - Otherwise imem_req=1 when count + pending_push < DEPTH and redirect=0.
  - imem_addr=fetch_pc; it is stable while imem_req=1.
  - At most one request is outstanding.
- Acceptance: an edge with imem_req=1 and imem_ack=1 completes the request.
  - If discard=0 and redirect=0: push {fetch_pc, imem_rdata} and set fetch_pc <= fetch_pc+2. The increment wraps modulo 2^16, so 16'hFFFE goes to 16'h0000.
  - If discard=1: drop the data, clear discard, and leave fetch_pc unchanged.
- Pop: ir_valid & ir_ready advances the read pointer.
- Push and pop in the same cycle are both allowed; count is unchanged.
- The issue rule guarantees an acked word always has space. The FIFO never overflows and there is no backpressure on memory.
- Redirect takes priority over everything else:
  - count <= 0 and pointers reset.
  - fetch_pc <= {redirect_pc[15:1],1'b0}.
  - A same-cycle pop is ignored.
  - A same-cycle ack is dropped.
- Redirect while a request is outstanding and not acked that cycle:
  - imem_req stays high with the old address until ack, with discard=1.
  - The discarded completion costs one request slot.
  - A new request to the target issues on the cycle after that ack.
- Consecutive redirects: the last one wins.
- ir and ir_pc show the head entry when ir_valid=1. They hold their last value when the queue is empty.

## Timing
- Reset values:
  - imem_req=0, imem_addr=PC_RESET
  - ir=0, ir_pc=0, ir_valid=0
  - count=0, outstanding=0, discard=0
- Reset mid-transaction abandons the request. Memory must tolerate req dropping before ack.
- First imem_req=1 in the first cycle after rst_n deasserts.
- Ack latency:
  - Ack in cycle n makes ir_valid=1 in cycle n+1 (registered FIFO).
  - With same-cycle ack, throughput is 1 instruction/cycle and imem_req stays high continuously while space exists.
- Redirect:
  - Redirect in cycle n gives ir_valid=0 in cycle n+1.
  - If no request is outstanding, the target request issues in n+1 and its ir_valid appears at the earliest in n+2.
- Full queue: imem_req=0 until a pop, then re-issues the cycle after the pop.

## Structure
- Shared package/constants file:
  - IW=16 (instruction width) and AW=16 (address width).
  - Default DEPTH.
  - PC increment of 2.
  - Fetch entry layout {pc, instr}, shared with the decode stage.
- One sub-module, fetch_fifo: synchronous FIFO with push, pop, flush, count, head data, and async active-low reset.
- Issue/discard control stays in the top level.

## Test plan
- Reset release, memory acking same cycle with rdata = address-derived pattern, ir_ready=1:
  - imem_addr goes 0000, 0002, 0004, …
  - ir_pc/ir follow one cycle later, one instruction per cycle.
- ir_ready=0 with immediate ack:
  - After 4 acks, imem_req=0 and ir_valid=1 with ir_pc=0000.
  - Raise ir_ready for one cycle: ir_pc=0002 and a single new request to 0008.
- Ack latency 3 cycles, redirect to 0x0040 issued one cycle after the request to 0x0006:
  - The 0x0006 response is dropped.
  - Next request is 0x0040 and the first ir_pc after the flush is 0x0040.
- Redirect in the same cycle as ack and pop, redirect_pc=16'h0013:
  - Queue empty next cycle.
  - Next imem_addr=0x0012 and the acked word never appears.
- Start at fetch address 0xFFFC (via PC_RESET or redirect) with immediate ack:
  - Addresses go FFFC, FFFE, 0000, with ir_pc matching.
- Assert rst_n=0 asynchronously mid-request with 2 queued entries:
  - All outputs take reset values immediately.
  - After release, fetch restarts at PC_RESET.
